// File: rtl/load_store_unit.sv
// Load/store unit between an RV32I core and a word-addressed data memory with combinational reads.
// Latency accept-to-done: fault 1, load/SW 2, SB/SH 3 cycles. ready is high only in IDLE; requests arriving while busy are dropped.
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_write_data,
    input  logic [31:0]           mem_read_data
);
    typedef enum logic [1:0] {IDLE, LOAD, RMW_READ, STORE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH+1:0] r_addr;
    logic [2:0]            r_funct3;
    logic [15:0]           r_wdata;
    logic [31:0]           r_merge;
    logic [31:0]           r_rdata;
    logic                  r_done;
    logic                  r_err;
    logic                  w_accept;
    logic                  w_bad_code;
    logic                  w_misalign;
    logic                  w_fault;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_merge;
    logic [31:0]           w_load;
    logic                  w_unused;

    // Address bits above the memory size wrap away.
    assign w_unused   = &{1'b0, addr[31:ADDR_WIDTH+2]};
    assign w_accept   = req && (r_state == IDLE);
    assign w_bad_code = we ? (funct3[2] || (funct3[1:0] == 2'b11))
                           : ((funct3[1:0] == 2'b11) || (funct3[2:1] == 2'b11));
    assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign w_fault    = w_bad_code || w_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_fault) begin
                    if (!we)                          w_next = LOAD;
                    else if (funct3[1:0] == 2'b10)    w_next = STORE;
                    else                              w_next = RMW_READ;
                end
            end
            LOAD:     w_next = IDLE;
            RMW_READ: w_next = STORE;
            STORE:    w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        ready        = 1'b0;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
        case (r_state)
            IDLE:           ready        = 1'b1;
            LOAD, RMW_READ: mem_read_en  = 1'b1;
            STORE:          mem_write_en = !rst;
            default:        ready        = 1'b0;
        endcase
    end

    assign w_byte = mem_read_data[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = mem_read_data[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = mem_read_data;
        endcase
    end

    always_comb begin
        w_merge = mem_read_data;
        if (r_funct3[0]) w_merge[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        else             w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_funct3 <= 3'b000;
            r_wdata  <= 16'h0;
            r_merge  <= 32'h0;
            r_rdata  <= 32'h0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= (w_accept && w_fault) || (r_state == LOAD) || (r_state == STORE);
            r_err  <= w_accept && w_fault;
            if (w_accept) begin
                r_addr   <= addr[ADDR_WIDTH+1:0];
                r_funct3 <= funct3;
                r_wdata  <= wdata[15:0];
            end
            // SW writes the store word straight from here; SB/SH overwrite it with the merged word.
            if (w_accept && we)        r_merge <= wdata;
            if (r_state == RMW_READ)   r_merge <= w_merge;
            if (r_state == LOAD)       r_rdata <= w_load;
        end
    end

    assign done           = r_done;
    assign err            = r_err;
    assign rdata          = r_rdata;
    assign mem_addr       = r_addr[ADDR_WIDTH+1:2];
    assign mem_write_data = r_merge;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors plus randomized ops against a byte-lane memory reference.
module tb_load_store_unit;
    logic        clk, rst, req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, mem_write_data, mem_read_data;
    logic        ready, done, err, mem_read_en, mem_write_en;
    logic [7:0]  mem_addr;

    logic [31:0] mem [256];
    logic [31:0] ref_mem [256];
    logic        fill, pl_en;
    logic [7:0]  pl_a;
    logic [31:0] pl_d;
    int          n_checks, n_errors;

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    assign mem_read_data = mem[mem_addr];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (pl_en) begin
            mem[pl_a] <= pl_d;
        end else if (mem_write_en) begin
            mem[mem_addr] <= mem_write_data;
        end
    end

    // Reference rules, expressed in bytes and lane arithmetic.
    function automatic bit ref_fault(input bit st, input logic [2:0] f, input logic [31:0] a);
        int size;
        if (st && !(f inside {3'b000, 3'b001, 3'b010})) return 1'b1;
        if (!st && (f inside {3'b011, 3'b110, 3'b111})) return 1'b1;
        size = 1 << f[1:0];
        return (int'(a[1:0]) % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f, input logic [31:0] a);
        logic [31:0] s, b, h;
        s = w >> (8 * int'(a[1:0]));
        b = s & 32'hFF;
        h = s & 32'hFFFF;
        case (f)
            3'b000:  return b - ((b & 32'h80) << 1);
            3'b001:  return h - ((h & 32'h8000) << 1);
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [2:0] f,
                                              input logic [31:0] a, input logic [31:0] d);
        int          sh;
        logic [31:0] m;
        if (f == 3'b010) return d;
        sh = 8 * int'(a[1:0]);
        m  = ((f == 3'b000) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~m) | ((d << sh) & m);
    endfunction

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    // Issues one request and observes the response; b2b drives it in the current (done) cycle.
    task automatic run_op(input bit b2b, input bit t_we, input logic [2:0] t_f, input logic [31:0] t_a,
                          input logic [31:0] t_d, output int lat, output logic e, output logic [31:0] rd,
                          output int nr, output int nw, output bit both);
        bit got;
        if (!b2b) begin
            @(posedge clk); #1;
        end
        req = 1'b1; we = t_we; funct3 = t_f; addr = t_a; wdata = t_d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = -1; e = 1'bx; rd = 32'hx; nr = 0; nw = 0; both = 1'b0; got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (mem_read_en === 1'b1) nr++;
            if (mem_write_en === 1'b1) nw++;
            if (mem_read_en === 1'b1 && mem_write_en === 1'b1) both = 1'b1;
            if (done === 1'b1) begin
                got = 1'b1; lat = c; e = err; rd = rdata;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; fill = 1'b1; pl_en = 1'b0; req = 1'b0; we = 1'b0;
        funct3 = 3'b000; addr = 32'h0; wdata = 32'h0; pl_a = 8'h0; pl_d = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; fill = 1'b0;
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_checks++; if ({mem_read_en, mem_write_en} !== 2'b00) begin n_errors++; $display("FAIL reset_mem_en got %b want 00", {mem_read_en, mem_write_en}); end
    endtask

    task automatic test_directed;
        int lat, nr, nw; logic e; logic [31:0] rd; bit bo;
        poke(8'd4, 32'h8899AABB);
        run_op(0, 0, 3'b000, 32'h13, 32'h0, lat, e, rd, nr, nw, bo);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL lb_latency got %0d want 2", lat); end
        n_checks++; if (rd !== 32'hFFFFFF88) begin n_errors++; $display("FAIL lb_rdata got %h want FFFFFF88", rd); end
        n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL lb_err got %b want 0", e); end
        run_op(0, 0, 3'b100, 32'h13, 32'h0, lat, e, rd, nr, nw, bo);
        n_checks++; if (rd !== 32'h00000088) begin n_errors++; $display("FAIL lbu_rdata got %h want 00000088", rd); end
        run_op(0, 0, 3'b101, 32'h12, 32'h0, lat, e, rd, nr, nw, bo);
        n_checks++; if (rd !== 32'h00008899) begin n_errors++; $display("FAIL lhu_rdata got %h want 00008899", rd); end
        run_op(0, 0, 3'b001, 32'h10, 32'h0, lat, e, rd, nr, nw, bo);
        n_checks++; if (rd !== 32'hFFFFAABB) begin n_errors++; $display("FAIL lh_rdata got %h want FFFFAABB", rd); end
        run_op(0, 1, 3'b000, 32'h11, 32'h1234565C, lat, e, rd, nr, nw, bo);
        n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL sb_latency got %0d want 3", lat); end
        n_checks++; if (mem[4] !== 32'h88995CBB) begin n_errors++; $display("FAIL sb_word got %h want 88995CBB", mem[4]); end
        n_checks++; if (nr !== 1 || nw !== 1) begin n_errors++; $display("FAIL sb_access got rd=%0d wr=%0d want 1/1", nr, nw); end
        n_checks++; if (rd !== 32'hFFFFAABB) begin n_errors++; $display("FAIL sb_rdata_hold got %h want FFFFAABB", rd); end
        ref_mem[4] = 32'h88995CBB;
        run_op(0, 1, 3'b001, 32'h11, 32'hCAFE, lat, e, rd, nr, nw, bo);
        n_checks++; if (lat !== 1 || e !== 1'b1) begin n_errors++; $display("FAIL sh_fault got lat=%0d err=%b want 1/1", lat, e); end
        n_checks++; if (nr !== 0 || nw !== 0) begin n_errors++; $display("FAIL sh_fault_access got rd=%0d wr=%0d want 0/0", nr, nw); end
        n_checks++; if (mem[4] !== 32'h88995CBB) begin n_errors++; $display("FAIL sh_fault_word got %h want 88995CBB", mem[4]); end
        run_op(0, 0, 3'b010, 32'h12, 32'h0, lat, e, rd, nr, nw, bo);
        n_checks++; if (lat !== 1 || e !== 1'b1) begin n_errors++; $display("FAIL lw_fault got lat=%0d err=%b want 1/1", lat, e); end
        n_checks++; if (nr !== 0 || nw !== 0) begin n_errors++; $display("FAIL lw_fault_access got rd=%0d wr=%0d want 0/0", nr, nw); end
        n_checks++; if (rd !== 32'hFFFFAABB) begin n_errors++; $display("FAIL lw_fault_rdata got %h want FFFFAABB", rd); end
    endtask

    task automatic test_reset_abort;
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'h00000077;
        @(posedge clk); #1;
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        if (done === 1'b1 || mem_write_en === 1'b1) seen = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done === 1'b1 || mem_write_en === 1'b1) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL abort_activity got done/write seen want none"); end
        n_checks++; if (mem[4] !== 32'h88995CBB) begin n_errors++; $display("FAIL abort_word got %h want 88995CBB", mem[4]); end
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL abort_ready got %b want 1", ready); end
        n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL abort_rdata got %h want 0", rdata); end
    endtask

    task automatic test_back_to_back;
        int lat, nr, nw; logic e; logic [31:0] rd; bit bo;
        run_op(0, 1, 3'b010, 32'h20, 32'hDEADBEEF, lat, e, rd, nr, nw, bo);
        n_checks++; if (lat !== 2 || nw !== 1 || nr !== 0) begin n_errors++; $display("FAIL sw_op got lat=%0d rd=%0d wr=%0d want 2/0/1", lat, nr, nw); end
        n_checks++; if (ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready got %b want 1", ready); end
        ref_mem[8] = 32'hDEADBEEF;
        run_op(1, 0, 3'b010, 32'h20, 32'h0, lat, e, rd, nr, nw, bo);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL b2b_lw_latency got %0d want 2", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL b2b_lw_rdata got %h want DEADBEEF", rd); end
    endtask

    task automatic test_random;
        int lat, nr, nw, xl, xr, xw; logic e; logic [31:0] rd, exp_rd, a, d; bit bo, st, flt, b2b;
        logic [2:0] f; logic [7:0] idx;
        exp_rd = 32'hDEADBEEF;
        for (int i = 0; i < 80; i++) begin
            st  = 1'($urandom_range(0, 1));
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            d   = $urandom;
            b2b = (i > 0) && ($urandom_range(0, 1) == 1);
            idx = a[9:2];
            flt = ref_fault(st, f, a);
            xl  = flt ? 1 : ((st && f != 3'b010) ? 3 : 2);
            xr  = (flt || (st && f == 3'b010)) ? 0 : 1;
            xw  = (!flt && st) ? 1 : 0;
            if (!flt && !st) exp_rd = ref_load(ref_mem[idx], f, a);
            if (!flt && st) ref_mem[idx] = ref_store(ref_mem[idx], f, a, d);
            run_op(b2b, st, f, a, d, lat, e, rd, nr, nw, bo);
            n_checks++; if (lat !== xl || e !== flt) begin n_errors++; $display("FAIL rnd%0d_done got lat=%0d err=%b want %0d/%b", i, lat, e, xl, flt); end
            n_checks++; if (rd !== exp_rd) begin n_errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, rd, exp_rd); end
            n_checks++; if (mem[idx] !== ref_mem[idx]) begin n_errors++; $display("FAIL rnd%0d_word got %h want %h", i, mem[idx], ref_mem[idx]); end
            n_checks++; if (nr !== xr || nw !== xw || bo !== 1'b0) begin n_errors++; $display("FAIL rnd%0d_access got rd=%0d wr=%0d both=%b want %0d/%0d/0", i, nr, nw, bo, xr, xw); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset;
        test_directed;
        test_reset_abort;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the word-address width of the downstream data memory.
REQ-003 The block SHALL have these ports, one per line:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req  in  1  core request, valid for one cycle
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- ready  out  1  high when a request can be accepted
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle fault pulse, coincident with done
- rdata  out  32  extended load result
- mem_read_en  out  1  to data memory read_en
- mem_write_en  out  1  to data memory write_en
- mem_addr  out  ADDR_WIDTH  word address to data memory
- mem_write_data  out  32  word written to data memory
- mem_read_data  in  32  combinational read word from data memory

Function
REQ-004 States SHALL be IDLE, LOAD, RMW_READ and STORE; ready SHALL be 1 only in IDLE.
REQ-005 A request SHALL be accepted on a rising edge where req=1 and state=IDLE; addr, we, funct3 and wdata SHALL be registered at that edge, and req in other states SHALL be ignored.
REQ-006 mem_addr SHALL be the registered addr[ADDR_WIDTH+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-007 Fault at accept: loads SHALL fault on funct3 in {011,110,111}; stores SHALL fault on funct3 not in {000,001,010}; H/HU/SH SHALL fault when addr[0]=1; W SHALL fault when addr[1:0]!=0.
REQ-008 A faulting request SHALL stay in IDLE, make no memory access, and pulse done=1 and err=1 in the cycle after accept; rdata SHALL be unchanged.
REQ-009 Load: IDLE->LOAD; in LOAD, mem_read_en=1; at the LOAD edge, rdata SHALL capture the byte or half selected by addr[1:0], sign-extended for B/H and zero-extended for BU/HU; state SHALL return to IDLE and done SHALL pulse in the next cycle (accept-to-done = 2 cycles).
REQ-010 Word store (SW): IDLE->STORE; in STORE, mem_write_en=1 and mem_write_data=wdata; then ->IDLE with a done pulse (accept-to-done = 2 cycles).
REQ-011 Sub-word store (SB/SH): IDLE->RMW_READ; in RMW_READ, mem_read_en=1; at that edge a merge register SHALL capture mem_read_data with the addressed byte or half replaced by wdata[7:0] or wdata[15:0]. Then ->STORE, which writes the merge register, then ->IDLE with a done pulse (accept-to-done = 3 cycles).
REQ-012 mem_read_en and mem_write_en SHALL never be high in the same cycle; both SHALL be 0 in IDLE.
REQ-013 Stores SHALL NOT modify rdata; rdata SHALL hold the last load result until the next successful load.
REQ-014 A request accepted in the same cycle that done is high (back-to-back) SHALL be processed normally.
REQ-015 mem_write_en SHALL be gated by !rst, so no memory write commits at an edge where rst=1.

Reset
REQ-016 At a rising edge with rst=1, the block SHALL enter IDLE and set done=0, err=0, rdata=0 and the merge register to 0; ready=1 from the next cycle.
REQ-017 Reset SHALL abort any in-flight operation with no partial write and no done pulse; memory contents are not reset.

Verification
REQ-018 Setup: memory word 4 = 0x8899AABB. LB addr 0x13 -> done 2 cycles after accept, rdata=0xFFFFFF88, err=0.
REQ-019 LBU addr 0x13 -> rdata=0x00000088; LHU addr 0x12 -> rdata=0x00008899; LH addr 0x10 -> rdata=0xFFFFAABB.
REQ-020 SB addr 0x11, wdata 0x1234565C -> one RMW_READ cycle and one STORE cycle; word 4 becomes 0x88995CBB; done 3 cycles after accept.
REQ-021 SH addr 0x11 or LW addr 0x12 -> done=err=1 one cycle after accept; mem_read_en and mem_write_en stay 0; word 4 unchanged.
REQ-022 rst=1 during RMW_READ of SB addr 0x10 -> no write occurs, word 4 unchanged, no done pulse; ready=1 and rdata=0 after reset.
REQ-023 Back-to-back: SW addr 0x20 with 0xDEADBEEF, then LW addr 0x20 accepted in the SW done cycle -> rdata=0xDEADBEEF.
